// File: rtl/countdown_pkg.sv
// Shared types and constants for the mm:ss countdown timer.
//   state_e      : FSM state encoding (idle, counting, paused, alarm)
//   UNITS_MAX    : largest BCD units digit (9)
//   TENS_MAX     : largest tens digit for minutes/seconds (5)
//   clamp_digit  : saturates a preset digit to its limit
package countdown_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StPaused = 2'd2,
    StAlarm  = 2'd3
  } state_e;

  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  function automatic logic [3:0] clamp_digit(input logic [3:0] value, input logic [3:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the board clock down to the countdown tick rate.
//   clk   : board clock
//   reset : asynchronous active-low reset
//   run   : advance the divider this cycle
//   clear : force the divider back to 0 (takes priority over run)
//   tick  : high while the divider sits at DIV-1; the consumer qualifies it
//           with its own RUN state, so a held terminal count is harmless
module tick_prescaler #(
  parameter int unsigned REFERENCE_CLOCK = 50_000_000,
  parameter int unsigned TICK_HZ         = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int unsigned DIV   = REFERENCE_CLOCK / TICK_HZ;
  localparam int unsigned Width = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [Width-1:0] MaxCnt = Width'(DIV - 1);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == MaxCnt) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == MaxCnt);

endmodule

// File: rtl/countdown_timer.sv
// mm:ss down-counter with latched alarm at 00:00.
//   clk, reset          : board clock, asynchronous active-low reset
//   load                : copy (clamped) preset into the count in idle/paused
//   set_m_t .. set_s_u  : BCD preset digits
//   start, pause        : begin/resume and suspend counting
//   alarm_off           : acknowledge alarm, return to idle
//   m_t, m_u, s_t, s_u  : current BCD digits (registered)
//   running, alarm      : registered state flags
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned REFERENCE_CLOCK = 50_000_000,
  parameter int unsigned TICK_HZ         = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] set_m_t,
  input  logic [3:0] set_m_u,
  input  logic [2:0] set_s_t,
  input  logic [3:0] set_s_u,
  input  logic       start,
  input  logic       pause,
  input  logic       alarm_off,
  output logic [2:0] m_t,
  output logic [3:0] m_u,
  output logic [2:0] s_t,
  output logic [3:0] s_u,
  output logic       running,
  output logic       alarm
);

  state_e state_q;

  logic tick;
  logic pre_run;
  logic pre_clear;

  // Pause on the terminal count holds the divider at DIV-1 so the dropped
  // tick fires on the first RUN cycle after resume.
  assign pre_run   = (state_q == StRun) && !(pause && tick);
  assign pre_clear = (state_q == StIdle) || (state_q == StAlarm);

  tick_prescaler #(
    .REFERENCE_CLOCK(REFERENCE_CLOCK),
    .TICK_HZ        (TICK_HZ)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .run  (pre_run),
    .clear(pre_clear),
    .tick (tick)
  );

  // Clamped preset digits.
  logic [3:0] clamp_m_t, clamp_s_t;
  logic [3:0] ld_m_u, ld_s_u;
  logic [2:0] ld_m_t, ld_s_t;

  always_comb begin
    clamp_m_t = clamp_digit({1'b0, set_m_t}, TENS_MAX);
    clamp_s_t = clamp_digit({1'b0, set_s_t}, TENS_MAX);
    ld_m_t    = clamp_m_t[2:0];
    ld_s_t    = clamp_s_t[2:0];
    ld_m_u    = clamp_digit(set_m_u, UNITS_MAX);
    ld_s_u    = clamp_digit(set_s_u, UNITS_MAX);
  end

  // BCD borrow chain for one decrement.
  logic       borrow_su, borrow_st, borrow_mu;
  logic [2:0] dec_m_t, dec_s_t;
  logic [3:0] dec_m_u, dec_s_u;
  logic       at_zero, at_one;

  always_comb begin
    borrow_su = (s_u == 4'd0);
    borrow_st = borrow_su && (s_t == 3'd0);
    borrow_mu = borrow_st && (m_u == 4'd0);
    dec_s_u   = borrow_su ? UNITS_MAX : s_u - 4'd1;
    dec_s_t   = s_t;
    if (borrow_su) begin
      dec_s_t = (s_t == 3'd0) ? TENS_MAX[2:0] : s_t - 3'd1;
    end
    dec_m_u = m_u;
    if (borrow_st) begin
      dec_m_u = (m_u == 4'd0) ? UNITS_MAX : m_u - 4'd1;
    end
    dec_m_t = borrow_mu ? m_t - 3'd1 : m_t;
    at_zero = (m_t == 3'd0) && (m_u == 4'd0) && (s_t == 3'd0) && (s_u == 4'd0);
    at_one  = (m_t == 3'd0) && (m_u == 4'd0) && (s_t == 3'd0) && (s_u == 4'd1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      m_t     <= '0;
      m_u     <= '0;
      s_t     <= '0;
      s_u     <= '0;
      running <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StPaused: begin
          if (load) begin
            m_t <= ld_m_t;
            m_u <= ld_m_u;
            s_t <= ld_s_t;
            s_u <= ld_s_u;
          end else if (pause) begin
            // Nothing to suspend; pause outranks start.
          end else if (start && !at_zero) begin
            state_q <= StRun;
            running <= 1'b1;
          end
        end
        StRun: begin
          if (pause) begin
            state_q <= StPaused;
            running <= 1'b0;
          end else if (tick) begin
            if (at_one || at_zero) begin
              m_t     <= '0;
              m_u     <= '0;
              s_t     <= '0;
              s_u     <= '0;
              state_q <= StAlarm;
              running <= 1'b0;
              alarm   <= 1'b1;
            end else begin
              m_t <= dec_m_t;
              m_u <= dec_m_u;
              s_t <= dec_s_t;
              s_u <= dec_s_u;
            end
          end
        end
        StAlarm: begin
          if (alarm_off) begin
            state_q <= StIdle;
            alarm   <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          running <= 1'b0;
          alarm   <= 1'b0;
        end
      endcase
    end
  end

endmodule
